// File: rtl/lr_predictor.sv
// lr_predictor: applies a fitted line y_hat = B0 + B1*X to a stream of X/Y samples.
//
// The fit (B1, B0, MSE) comes from the 8-point linear-regression engine. This block
// latches it on coef_valid, then streams samples through a 3-stage pipeline. For each
// sample it produces the saturated prediction, the saturated residual Y - y_hat and a
// saturation flag.
//
// A new fit that arrives while running goes into shadow registers. Input is then held
// off until the pipeline drains, so every in-flight sample finishes with the
// coefficients that were active when it was accepted.
//
// Compile-time option:
//   LR_PRED_OUTLIER_EN  when defined, S3 squares the residual and raises outlier when
//                       residual^2 > (MSE << THR_SHIFT), compared unsigned.
//                       When undefined, outlier is tied to 0.
//
// Ports:
//   clk, rst              clock (rising edge); asynchronous active-low reset
//   coef_valid, B1/B0/MSE 1-cycle strobe with a new fit (B1/B0 signed, MSE unsigned)
//   x_valid/x_ready, X/Y  sample handshake and signed sample pair
//   out_valid/out_ready   result handshake; the pipeline freezes on out_valid & !out_ready
//   y_hat, residual       saturated signed results
//   sat, outlier          clip flag and optional outlier flag
//   coef_loaded           a fit is active
//   sample_cnt            results delivered since the last coefficient load (wraps)
module lr_predictor #(
   parameter int unsigned XW        = 16,
   parameter int unsigned CW        = 32,
   parameter int unsigned THR_SHIFT = 2,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             coef_valid,
   input  logic [CW-1:0]    B1,
   input  logic [CW-1:0]    B0,
   input  logic [CW-1:0]    MSE,
   input  logic             x_valid,
   output logic             x_ready,
   input  logic [XW-1:0]    X,
   input  logic [XW-1:0]    Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    y_hat,
   output logic [CW-1:0]    residual,
   output logic             sat,
   output logic             outlier,
   output logic             coef_loaded,
   output logic [CNT_W-1:0] sample_cnt
);

   localparam int unsigned PW = CW + XW;  // product width
   localparam int unsigned SW = PW + 1;   // product + intercept, cannot overflow
   localparam int unsigned RW = CW + 1;   // residual before clipping

   localparam logic [CW-1:0] MaxPos = {1'b0, {(CW-1){1'b1}}};
   localparam logic [CW-1:0] MinNeg = {1'b1, {(CW-1){1'b0}}};

   typedef enum logic [1:0] {StNoCoef, StRun, StDrain} state_e;

   state_e state_q, state_d;

   logic [CW-1:0] b1_q, b0_q, b1_sh_q, b0_sh_q;
   logic          load_active, load_shadow, load_from_input, cnt_clear;

   logic          v1_q, v2_q, v3_q;
   logic [XW-1:0] x1_q, y1_q, y2_q;
   logic [PW-1:0] prod_q, prod_c;
   logic [SW-1:0] sum_c;
   logic [RW-1:0] res_c;
   logic [CW-1:0] yhat_c, res_sat_c, y_hat_q, residual_q;
   logic          sum_fits, res_fits, sat_c, sat_q, outlier_c, outlier_q;
   logic [CNT_W-1:0] cnt_q;

   logic stall, advance, accept, pipe_empty;

   assign stall      = v3_q & ~out_ready;
   assign advance    = ~stall;
   assign x_ready    = (state_q == StRun) & ~stall;
   assign accept     = x_valid & x_ready;
   assign pipe_empty = ~(v1_q | v2_q | v3_q);

   // ---------------------------------------------------------------------------
   // Coefficient FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d         = state_q;
      load_active     = 1'b0;
      load_shadow     = 1'b0;
      load_from_input = 1'b0;
      cnt_clear       = 1'b0;
      unique case (state_q)
         StNoCoef: begin
            if (coef_valid) begin
               state_d         = StRun;
               load_active     = 1'b1;
               load_from_input = 1'b1;
               cnt_clear       = 1'b1;
            end
         end
         StRun: begin
            if (coef_valid) begin
               state_d     = StDrain;
               load_shadow = 1'b1;
            end
         end
         StDrain: begin
            if (coef_valid) load_shadow = 1'b1;
            if (pipe_empty) begin
               state_d     = StRun;
               load_active = 1'b1;
               // A strobe on the exit cycle is the newest fit; take it directly.
               load_from_input = coef_valid;
               cnt_clear       = 1'b1;
            end
         end
         default: state_d = StNoCoef;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StNoCoef;
         b1_q    <= '0;
         b0_q    <= '0;
         b1_sh_q <= '0;
         b0_sh_q <= '0;
      end else begin
         state_q <= state_d;
         if (load_shadow) begin
            b1_sh_q <= B1;
            b0_sh_q <= B0;
         end
         if (load_active) begin
            b1_q <= load_from_input ? B1 : b1_sh_q;
            b0_q <= load_from_input ? B0 : b0_sh_q;
         end
      end
   end

`ifdef LR_PRED_OUTLIER_EN
   logic [CW-1:0]   mse_q, mse_sh_q;
   logic [2*CW-1:0] sq_c, thr_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mse_q    <= '0;
         mse_sh_q <= '0;
      end else begin
         if (load_shadow) mse_sh_q <= MSE;
         if (load_active) mse_q <= load_from_input ? MSE : mse_sh_q;
      end
   end

   // Square of a signed value is never negative, so the 2*CW result is read as unsigned.
   assign sq_c  = $signed({{CW{res_sat_c[CW-1]}}, res_sat_c}) *
                  $signed({{CW{res_sat_c[CW-1]}}, res_sat_c});
   assign thr_c = {{CW{1'b0}}, mse_q} << THR_SHIFT;
   assign outlier_c = sq_c > thr_c;
`else
   logic unused_mse;
   localparam int unsigned unused_thr_shift = THR_SHIFT;
   assign unused_mse = ^MSE;
   assign outlier_c  = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   assign prod_c = $signed({{XW{b1_q[CW-1]}}, b1_q}) * $signed({{CW{x1_q[XW-1]}}, x1_q});

   always_comb begin
      sum_c = {prod_q[PW-1], prod_q} + {{(SW-CW){b0_q[CW-1]}}, b0_q};
      // Fits in CW bits when every bit from the CW-1 sign position upward agrees.
      sum_fits = (&sum_c[SW-1:CW-1]) | ~(|sum_c[SW-1:CW-1]);
      if (sum_fits)          yhat_c = sum_c[CW-1:0];
      else if (sum_c[SW-1])  yhat_c = MinNeg;
      else                   yhat_c = MaxPos;

      res_c    = {{(RW-XW){y2_q[XW-1]}}, y2_q} - {yhat_c[CW-1], yhat_c};
      res_fits = (res_c[CW] == res_c[CW-1]);
      if (res_fits)        res_sat_c = res_c[CW-1:0];
      else if (res_c[CW])  res_sat_c = MinNeg;
      else                 res_sat_c = MaxPos;

      sat_c = ~sum_fits | ~res_fits;
   end

   // Every stage advances together; a stalled output freezes the whole pipe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         x1_q       <= '0;
         y1_q       <= '0;
         y2_q       <= '0;
         prod_q     <= '0;
         y_hat_q    <= '0;
         residual_q <= '0;
         sat_q      <= 1'b0;
         outlier_q  <= 1'b0;
      end else if (advance) begin
         v1_q <= accept;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (accept) begin
            x1_q <= X;
            y1_q <= Y;
         end
         if (v1_q) begin
            prod_q <= prod_c;
            y2_q   <= y1_q;
         end
         if (v2_q) begin
            y_hat_q    <= yhat_c;
            residual_q <= res_sat_c;
            sat_q      <= sat_c;
            outlier_q  <= outlier_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (cnt_clear) begin
         cnt_q <= '0;
      end else if (v3_q && out_ready) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign out_valid   = v3_q;
   assign y_hat       = y_hat_q;
   assign residual    = residual_q;
   assign sat         = sat_q;
   assign outlier     = outlier_q;
   assign coef_loaded = (state_q != StNoCoef);
   assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_lr_predictor.sv
// Directed bench for lr_predictor: table of single-sample fits plus hand-written
// sequences for coefficient reload, output stall and mid-stream reset.
module tb_lr_predictor;

   localparam int XW    = 16;
   localparam int CW    = 32;
   localparam int CNT_W = 16;
`ifdef LR_PRED_OUTLIER_EN
   localparam bit OutEn = 1'b1;
`else
   localparam bit OutEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             coef_valid;
   logic [CW-1:0]    B1, B0, MSE;
   logic             x_valid, x_ready;
   logic [XW-1:0]    X, Y;
   logic             out_valid, out_ready;
   logic [CW-1:0]    y_hat, residual;
   logic             sat, outlier, coef_loaded;
   logic [CNT_W-1:0] sample_cnt;

   always #5 clk = ~clk;

   lr_predictor #(.XW(XW), .CW(CW), .THR_SHIFT(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .coef_valid(coef_valid), .B1(B1), .B0(B0), .MSE(MSE),
      .x_valid(x_valid), .x_ready(x_ready), .X(X), .Y(Y),
      .out_valid(out_valid), .out_ready(out_ready), .y_hat(y_hat), .residual(residual),
      .sat(sat), .outlier(outlier), .coef_loaded(coef_loaded), .sample_cnt(sample_cnt)
   );

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] got_q[$];
   always @(negedge clk) if (rst && out_valid && out_ready) got_q.push_back(y_hat);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock; acc reports whether a sample handshake happens at this edge.
   task automatic cycle(output bit acc);
      @(negedge clk);
      acc = x_valid && x_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic load_coef(input logic [CW-1:0] b1, input logic [CW-1:0] b0,
                            input logic [CW-1:0] mse);
      coef_valid = 1'b1;
      B1 = b1;
      B0 = b0;
      MSE = mse;
      tick();
      coef_valid = 1'b0;
      for (int i = 0; i < 20 && !x_ready; i++) tick();
      check("coef_ready", x_ready, 1);
   endtask

   typedef struct {
      logic [CW-1:0] b1, b0, mse;
      logic [XW-1:0] x, y;
      logic [CW-1:0] yh, res;
      logic          sat, outl;
   } vec_t;

   vec_t vt[9];

   initial begin
      bit acc;
      int sent;

      vt[0] = '{32'd2, 32'd3, 32'd1, 16'd5, 16'd14, 32'd13, 32'd1, 1'b0, 1'b0};
      vt[1] = '{32'd1, 32'd0, 32'd1, 16'd0, 16'd3, 32'd0, 32'd3, 1'b0, 1'b1};
      vt[2] = '{32'd1, 32'd0, 32'd1, 16'd0, 16'd2, 32'd0, 32'd2, 1'b0, 1'b0};
      vt[3] = '{32'h7FFFFFFF, 32'd0, 32'd1, 16'd2, 16'd0, 32'h7FFFFFFF, 32'h80000001,
                1'b1, 1'b1};
      vt[4] = '{32'h80000000, 32'hFFFFFFFF, 32'd1, 16'd1, 16'd0, 32'h80000000,
                32'h7FFFFFFF, 1'b1, 1'b1};
      vt[5] = '{32'hFFFFFFFD, 32'd100, 32'd1000, 16'hFFF9, 16'hFFCE, 32'd121,
                32'hFFFFFF55, 1'b0, 1'b1};
      vt[6] = '{32'd1, 32'd0, 32'd0, 16'd4, 16'd5, 32'd4, 32'd1, 1'b0, 1'b1};
      vt[7] = '{32'd0, 32'h7FFFFFFF, 32'd5, 16'd9, 16'hFFFF, 32'h7FFFFFFF, 32'h80000000,
                1'b0, 1'b1};
      vt[8] = '{32'd0, 32'h7FFFFFFF, 32'd5, 16'd9, 16'hFFFE, 32'h7FFFFFFF, 32'h80000000,
                1'b1, 1'b1};

      rst = 1'b0;
      coef_valid = 1'b0;
      B1 = '0;
      B0 = '0;
      MSE = '0;
      x_valid = 1'b0;
      X = '0;
      Y = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_y_hat", y_hat, 0);
      check("rst_residual", residual, 0);
      check("rst_flags", {sat, outlier, coef_loaded}, 0);
      check("rst_sample_cnt", sample_cnt, 0);

      // No fit loaded: samples must be refused
      x_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("nocoef_idle", {x_ready, out_valid, coef_loaded}, 0);
      end
      x_valid = 1'b0;

      // Table of single-sample fits
      for (int i = 0; i < 9; i++) begin
         load_coef(vt[i].b1, vt[i].b0, vt[i].mse);
         check("coef_loaded", coef_loaded, 1);
         X = vt[i].x;
         Y = vt[i].y;
         x_valid = 1'b1;
         tick();
         x_valid = 1'b0;
         check("lat_edge1", out_valid, 0);
         tick();
         check("lat_edge2", out_valid, 0);
         tick();
         check("lat_edge3", out_valid, 1);
         check("vec_y_hat", y_hat, vt[i].yh);
         check("vec_residual", residual, vt[i].res);
         check("vec_sat", sat, vt[i].sat);
         check("vec_outlier", outlier, OutEn ? vt[i].outl : 1'b0);
         check("vec_cnt_before", sample_cnt, 0);
         tick();
         check("vec_cnt_after", sample_cnt, 1);
         check("vec_drained", out_valid, 0);
      end

      // Coefficient reload mid-stream: B1=1 for two samples, B1=3 for the next two
      load_coef(32'd1, 32'd0, 32'hFFFF);
      got_q.delete();
      Y = '0;
      X = 16'd10;
      x_valid = 1'b1;
      cycle(acc);
      check("reload_acc1", acc, 1);
      X = 16'd20;
      cycle(acc);
      check("reload_acc2", acc, 1);
      x_valid = 1'b0;
      coef_valid = 1'b1;
      B1 = 32'd3;
      tick();
      coef_valid = 1'b0;
      check("reload_hold", x_ready, 0);
      X = 16'd30;
      x_valid = 1'b1;
      for (int i = 0; i < 20 && !x_ready; i++) tick();
      check("reload_resume", x_ready, 1);
      check("reload_cnt_clear", sample_cnt, 0);
      check("reload_pipe_empty", got_q.size(), 2);
      cycle(acc);
      X = 16'd40;
      cycle(acc);
      x_valid = 1'b0;
      for (int i = 0; i < 20 && got_q.size() < 4; i++) tick();
      tick();
      check("reload_count", got_q.size(), 4);
      if (got_q.size() == 4) begin
         check("reload_s1", got_q[0], 10);
         check("reload_s2", got_q[1], 20);
         check("reload_s3", got_q[2], 90);
         check("reload_s4", got_q[3], 120);
      end
      check("reload_cnt_final", sample_cnt, 2);

      // Output stall with a full pipe
      load_coef(32'd1, 32'd0, 32'hFFFF);
      got_q.delete();
      out_ready = 1'b0;
      sent = 0;
      X = 16'd1;
      x_valid = 1'b1;
      for (int i = 0; i < 10 && !out_valid; i++) begin
         cycle(acc);
         if (acc) begin
            sent++;
            X = XW'(sent + 1);
         end
      end
      check("stall_valid", out_valid, 1);
      check("stall_fill", sent, 3);
      for (int i = 0; i < 5; i++) begin
         cycle(acc);
         if (acc) sent++;
         check("stall_frozen", {out_valid, x_ready, y_hat}, {2'b10, 32'd1});
      end
      check("stall_cnt", sample_cnt, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && sent < 5; i++) begin
         cycle(acc);
         if (acc) begin
            sent++;
            X = XW'(sent + 1);
         end
      end
      x_valid = 1'b0;
      for (int i = 0; i < 20 && got_q.size() < 5; i++) tick();
      check("stall_count", got_q.size(), 5);
      for (int k = 0; k < 5 && k < got_q.size(); k++) check("stall_order", got_q[k], k + 1);

      // Reset asserted mid-stream
      got_q.delete();
      X = 16'd7;
      x_valid = 1'b1;
      cycle(acc);
      cycle(acc);
      rst = 1'b0;
      #1;
      check("mrst_valid_ready", {out_valid, x_ready}, 0);
      check("mrst_y_hat", y_hat, 0);
      check("mrst_residual", residual, 0);
      check("mrst_flags", {sat, outlier, coef_loaded}, 0);
      check("mrst_cnt", sample_cnt, 0);
      tick();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mrst_idle", {x_ready, out_valid, coef_loaded}, 0);
      end
      check("mrst_dropped", got_q.size(), 0);
      x_valid = 1'b0;
      load_coef(32'd2, 32'd3, 32'd1);
      check("mrst_reloaded", coef_loaded, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
